// File: rtl/alu_pkg.sv
// Shared types and constants for the registered integer ALU.
// Command encodings are split per mode; flags travel as one packed bundle.
package alu_pkg;

    localparam int W_DEF     = 8;
    localparam int CMD_W_DEF = 4;

    localparam logic MODE_ARITH = 1'b1;
    localparam logic MODE_LOGIC = 1'b0;

    typedef enum logic [3:0] {
        CMD_ADD     = 4'd0,
        CMD_SUB     = 4'd1,
        CMD_ADD_CIN = 4'd2,
        CMD_SUB_CIN = 4'd3,
        CMD_INC_A   = 4'd4,
        CMD_DEC_A   = 4'd5,
        CMD_INC_B   = 4'd6,
        CMD_DEC_B   = 4'd7,
        CMD_CMP     = 4'd8,
        CMD_MUL_INC = 4'd9,
        CMD_MUL_SHL = 4'd10
    } arith_cmd_e;

    typedef enum logic [3:0] {
        CMD_AND     = 4'd0,
        CMD_NAND    = 4'd1,
        CMD_OR      = 4'd2,
        CMD_NOR     = 4'd3,
        CMD_XOR     = 4'd4,
        CMD_XNOR    = 4'd5,
        CMD_NOT_A   = 4'd6,
        CMD_NOT_B   = 4'd7,
        CMD_SHR1_A  = 4'd8,
        CMD_SHL1_A  = 4'd9,
        CMD_SHR1_B  = 4'd10,
        CMD_SHL1_B  = 4'd11,
        CMD_ROL_A_B = 4'd12,
        CMD_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef struct packed {
        logic cout;
        logic oflow;
        logic g;
        logic l;
        logic e;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_if.sv
// Operand/command bundle into the ALU and registered result bundle out.
// done pulses on each enabled edge that writes a new result.
import alu_pkg::*;

interface alu_if #(
    parameter int W     = W_DEF,
    parameter int CMD_W = CMD_W_DEF
);
    logic             ce;
    logic [1:0]       inp_valid;
    logic             mode;
    logic [CMD_W-1:0] cmd;
    logic [W-1:0]     opa;
    logic [W-1:0]     opb;
    logic             cin;

    logic [2*W-1:0]   res;
    logic             cout;
    logic             oflow;
    logic             g;
    logic             l;
    logic             e;
    logic             err;
    logic             done;

    modport master (
        output ce, inp_valid, mode, cmd, opa, opb, cin,
        input  res, cout, oflow, g, l, e, err, done
    );

    modport slave (
        input  ce, inp_valid, mode, cmd, opa, opb, cin,
        output res, cout, oflow, g, l, e, err, done
    );
endinterface

// File: rtl/alu_mul_stage.sv
// Two-edge multiplier: operands captured on issue, product on the next enabled edge.
// out_valid stays up while the product is the live result, until clr.
import alu_pkg::*;

module alu_mul_stage #(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ce,
    input  logic           in_valid,
    input  logic           clr,
    input  logic [2*W-1:0] x,
    input  logic [2*W-1:0] y,
    output logic [2*W-1:0] p,
    output logic           out_valid
);
    logic [2*W-1:0] x_q;
    logic [2*W-1:0] y_q;
    logic           v1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            v1        <= 1'b0;
            p         <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            v1 <= in_valid;
            if (in_valid) begin
                x_q <= x;
                y_q <= y;
            end
            if (v1) begin
                p         <= x_q * y_q;
                out_valid <= 1'b1;
            end else if (clr) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Registered integer ALU: decode, operand check, arith/logic datapath,
// output registers and the busy flag covering the multiply's second cycle.
import alu_pkg::*;

module alu_unit #(
    parameter int W     = W_DEF,
    parameter int CMD_W = CMD_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    localparam int W2 = 2 * W;
    localparam int SW = $clog2(W);

    logic [W2-1:0] a2, b2;
    logic [W2-1:0] sum_ab, sum_abc, inc_a, inc_b;
    logic [W-1:0]  dif_ab, dif_abc, dec_a, dec_b;
    logic          brw_abc;
    logic [W-1:0]  shl_a, shl_b;
    logic [SW-1:0] rot_amt;
    logic          rot_hi;
    logic [W-1:0]  rol_a, ror_a;
    logic [3:0]    cmd4;
    logic          cmd_hi;

    assign a2      = {{W{1'b0}}, bus.opa};
    assign b2      = {{W{1'b0}}, bus.opb};
    assign sum_ab  = a2 + b2;
    assign sum_abc = a2 + b2 + W2'(bus.cin);
    assign inc_a   = a2 + W2'(1);
    assign inc_b   = b2 + W2'(1);
    assign dif_ab  = bus.opa - bus.opb;
    assign dif_abc = bus.opa - bus.opb - W'(bus.cin);
    assign brw_abc = a2 < (b2 + W2'(bus.cin));
    assign dec_a   = bus.opa - W'(1);
    assign dec_b   = bus.opb - W'(1);
    assign shl_a   = {bus.opa[W-2:0], 1'b0};
    assign shl_b   = {bus.opb[W-2:0], 1'b0};

    // Rotate uses only the low log2(W) bits; higher bits flag an error.
    assign rot_amt = bus.opb[SW-1:0];
    assign rot_hi  = |(bus.opb >> SW);
    assign rol_a   = (bus.opa << rot_amt) | (bus.opa >> (W - int'(rot_amt)));
    assign ror_a   = (bus.opa >> rot_amt) | (bus.opa << (W - int'(rot_amt)));

    assign cmd4   = bus.cmd[3:0];
    assign cmd_hi = (bus.cmd >> 4) != '0;

    logic [W2-1:0] r_res;
    logic [W-1:0]  l_res;
    flags_t        r_f;
    logic          need_a, need_b, known, is_mul;
    logic [W2-1:0] mx, my;

    always_comb begin
        r_res  = '0;
        l_res  = '0;
        r_f    = '0;
        need_a = 1'b0;
        need_b = 1'b0;
        known  = 1'b1;
        is_mul = 1'b0;
        mx     = '0;
        my     = '0;
        if (bus.mode == MODE_ARITH) begin
            case (arith_cmd_e'(cmd4))
                CMD_ADD: begin
                    {need_a, need_b} = 2'b11;
                    r_res     = sum_ab;
                    r_f.cout  = sum_ab[W];
                end
                CMD_SUB: begin
                    {need_a, need_b} = 2'b11;
                    r_res     = {{W{1'b0}}, dif_ab};
                    r_f.oflow = bus.opa < bus.opb;
                end
                CMD_ADD_CIN: begin
                    {need_a, need_b} = 2'b11;
                    r_res     = sum_abc;
                    r_f.cout  = sum_abc[W];
                end
                CMD_SUB_CIN: begin
                    {need_a, need_b} = 2'b11;
                    r_res     = {{W{1'b0}}, dif_abc};
                    r_f.oflow = brw_abc;
                end
                CMD_INC_A: begin
                    need_a    = 1'b1;
                    r_res     = inc_a;
                    r_f.cout  = inc_a[W];
                end
                CMD_DEC_A: begin
                    need_a    = 1'b1;
                    r_res     = {{W{1'b0}}, dec_a};
                    r_f.oflow = bus.opa == '0;
                end
                CMD_INC_B: begin
                    need_b    = 1'b1;
                    r_res     = inc_b;
                    r_f.cout  = inc_b[W];
                end
                CMD_DEC_B: begin
                    need_b    = 1'b1;
                    r_res     = {{W{1'b0}}, dec_b};
                    r_f.oflow = bus.opb == '0;
                end
                CMD_CMP: begin
                    {need_a, need_b} = 2'b11;
                    r_f.g = bus.opa > bus.opb;
                    r_f.l = bus.opa < bus.opb;
                    r_f.e = bus.opa == bus.opb;
                end
                CMD_MUL_INC: begin
                    {need_a, need_b} = 2'b11;
                    is_mul = 1'b1;
                    mx     = inc_a;
                    my     = inc_b;
                end
                CMD_MUL_SHL: begin
                    {need_a, need_b} = 2'b11;
                    is_mul = 1'b1;
                    mx     = {{W{1'b0}}, shl_a};
                    my     = b2;
                end
                default: known = 1'b0;
            endcase
        end else begin
            case (logic_cmd_e'(cmd4))
                CMD_AND: begin
                    {need_a, need_b} = 2'b11;
                    l_res = bus.opa & bus.opb;
                end
                CMD_NAND: begin
                    {need_a, need_b} = 2'b11;
                    l_res = ~(bus.opa & bus.opb);
                end
                CMD_OR: begin
                    {need_a, need_b} = 2'b11;
                    l_res = bus.opa | bus.opb;
                end
                CMD_NOR: begin
                    {need_a, need_b} = 2'b11;
                    l_res = ~(bus.opa | bus.opb);
                end
                CMD_XOR: begin
                    {need_a, need_b} = 2'b11;
                    l_res = bus.opa ^ bus.opb;
                end
                CMD_XNOR: begin
                    {need_a, need_b} = 2'b11;
                    l_res = ~(bus.opa ^ bus.opb);
                end
                CMD_NOT_A: begin
                    need_a = 1'b1;
                    l_res  = ~bus.opa;
                end
                CMD_NOT_B: begin
                    need_b = 1'b1;
                    l_res  = ~bus.opb;
                end
                CMD_SHR1_A: begin
                    need_a = 1'b1;
                    l_res  = bus.opa >> 1;
                end
                CMD_SHL1_A: begin
                    need_a = 1'b1;
                    l_res  = shl_a;
                end
                CMD_SHR1_B: begin
                    need_b = 1'b1;
                    l_res  = bus.opb >> 1;
                end
                CMD_SHL1_B: begin
                    need_b = 1'b1;
                    l_res  = shl_b;
                end
                CMD_ROL_A_B: begin
                    {need_a, need_b} = 2'b11;
                    l_res   = rol_a;
                    r_f.err = rot_hi;
                end
                CMD_ROR_A_B: begin
                    {need_a, need_b} = 2'b11;
                    l_res   = ror_a;
                    r_f.err = rot_hi;
                end
                default: known = 1'b0;
            endcase
            r_res = {{W{1'b0}}, l_res};
        end
    end

    logic          bad, mul_go;
    logic [W2-1:0] nxt_res;
    flags_t        nxt_f;

    // A missing operand or unknown command squashes everything but ERR.
    assign bad = ~known | cmd_hi
               | (need_a & ~bus.inp_valid[0])
               | (need_b & ~bus.inp_valid[1]);
    assign mul_go  = ~bad & is_mul;
    assign nxt_res = bad ? '0 : r_res;
    assign nxt_f   = bad ? flags_t'(6'b000001) : r_f;

    logic          busy;
    logic          done_q;
    logic [W2-1:0] res_q;
    flags_t        flags_q;
    logic [W2-1:0] mul_p;
    logic          mul_vo;

    alu_mul_stage #(.W(W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (bus.ce),
        .in_valid  (~busy & mul_go),
        .clr       (~busy & ~mul_go),
        .x         (mx),
        .y         (my),
        .p         (mul_p),
        .out_valid (mul_vo)
    );

    // Busy cycle: presented op is dropped while the product lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            flags_q <= '0;
            busy    <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.ce) begin
            if (busy) begin
                busy    <= 1'b0;
                flags_q <= '0;
                done_q  <= 1'b1;
            end else if (mul_go) begin
                busy   <= 1'b1;
                done_q <= 1'b0;
            end else begin
                res_q   <= nxt_res;
                flags_q <= nxt_f;
                done_q  <= 1'b1;
            end
        end
    end

    assign bus.res   = mul_vo ? mul_p : res_q;
    assign bus.cout  = flags_q.cout;
    assign bus.oflow = flags_q.oflow;
    assign bus.g     = flags_q.g;
    assign bus.l     = flags_q.l;
    assign bus.e     = flags_q.e;
    assign bus.err   = flags_q.err;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes model results, a monitor
// pops them on each done edge and checks hold behaviour otherwise.
module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_if #(.W(W), .CMD_W(4)) bus();

    alu_unit #(.W(W), .CMD_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] res;
        logic [5:0]  fl;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   vectors = 0;
    int   miscompares = 0;
    bit   busy_m = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", n, act, want);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic void model(input bit mode, input int cmd,
                                  input bit [1:0] iv, input int a,
                                  input int b, input int cin,
                                  output exp_t x, output bit mul);
        int r;
        int s;
        bit co, of, g, l, e, er, na, nb, ok;
        r = 0; co = 0; of = 0; g = 0; l = 0; e = 0; er = 0;
        na = 0; nb = 0; ok = 1; mul = 0;
        if (mode) begin
            case (cmd)
                0: begin na = 1; nb = 1; r = a + b; co = r > 255; end
                1: begin na = 1; nb = 1; r = (a - b) & 255; of = a < b; end
                2: begin na = 1; nb = 1; r = a + b + cin; co = r > 255; end
                3: begin
                    na = 1; nb = 1;
                    r = (a - b - cin) & 255; of = a < b + cin;
                end
                4: begin na = 1; r = a + 1; co = r > 255; end
                5: begin na = 1; r = (a - 1) & 255; of = a == 0; end
                6: begin nb = 1; r = b + 1; co = r > 255; end
                7: begin nb = 1; r = (b - 1) & 255; of = b == 0; end
                8: begin
                    na = 1; nb = 1;
                    g = a > b; l = a < b; e = a == b;
                end
                9: begin
                    na = 1; nb = 1; mul = 1;
                    r = ((a + 1) * (b + 1)) & 65535;
                end
                10: begin
                    na = 1; nb = 1; mul = 1;
                    r = (((a * 2) & 255) * b) & 65535;
                end
                default: ok = 0;
            endcase
        end else begin
            s = b % 8;
            case (cmd)
                0: begin na = 1; nb = 1; r = a & b; end
                1: begin na = 1; nb = 1; r = ~(a & b) & 255; end
                2: begin na = 1; nb = 1; r = a | b; end
                3: begin na = 1; nb = 1; r = ~(a | b) & 255; end
                4: begin na = 1; nb = 1; r = a ^ b; end
                5: begin na = 1; nb = 1; r = ~(a ^ b) & 255; end
                6: begin na = 1; r = ~a & 255; end
                7: begin nb = 1; r = ~b & 255; end
                8: begin na = 1; r = a / 2; end
                9: begin na = 1; r = (a * 2) & 255; end
                10: begin nb = 1; r = b / 2; end
                11: begin nb = 1; r = (b * 2) & 255; end
                12: begin
                    na = 1; nb = 1; er = b >= 8;
                    r = ((a << s) | (a >> (8 - s))) & 255;
                end
                13: begin
                    na = 1; nb = 1; er = b >= 8;
                    r = ((a >> s) | (a << (8 - s))) & 255;
                end
                default: ok = 0;
            endcase
        end
        if (!ok || (na && !iv[0]) || (nb && !iv[1])) begin
            r = 0; co = 0; of = 0; g = 0; l = 0; e = 0; er = 1; mul = 0;
        end
        x.res = r[15:0];
        x.fl  = {co, of, g, l, e, er};
    endfunction

    task automatic issue(input bit ce_i, input bit [1:0] iv, input bit mode,
                         input int cmd, input int a, input int b,
                         input int cin);
        exp_t x;
        bit   m;
        @(negedge clk);
        bus.ce        = ce_i;
        bus.inp_valid = iv;
        bus.mode      = mode;
        bus.cmd       = cmd[3:0];
        bus.opa       = a[7:0];
        bus.opb       = b[7:0];
        bus.cin       = cin[0];
        if (ce_i && rst_n) begin
            if (busy_m) begin
                busy_m = 0;
            end else begin
                model(mode, cmd, iv, a, b, cin, x, m);
                q.push_back(x);
                busy_m = m;
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.ce = 1'b0;
        #1;
        chk("reset_now", {bus.res, bus.cout, bus.oflow, bus.g, bus.l,
            bus.e, bus.err, bus.done}, 32'h0);
        q.delete();
        busy_m = 0;
        last_exp.res = '0;
        last_exp.fl  = '0;
        #1 rst_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic ce_e;
    logic rst_e;
    exp_t mx;

    initial begin
        forever begin
            @(posedge clk);
            ce_e  = bus.ce;
            rst_e = rst_n;
            #1;
            if (rst_e && rst_n) begin
                if (ce_e && bus.done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", 32'h1, 32'h0);
                    end else begin
                        mx = q.pop_front();
                        chk("result", {bus.res, bus.cout, bus.oflow, bus.g,
                            bus.l, bus.e, bus.err}, {mx.res, mx.fl});
                        last_exp = mx;
                    end
                end else begin
                    chk("hold", {bus.res, bus.cout, bus.oflow, bus.g, bus.l,
                        bus.e, bus.err}, {last_exp.res, last_exp.fl});
                end
            end
        end
    end

    initial begin
        int a, b;
        last_exp.res  = '0;
        last_exp.fl   = '0;
        bus.ce        = 1'b0;
        bus.inp_valid = 2'b00;
        bus.mode      = 1'b0;
        bus.cmd       = '0;
        bus.opa       = '0;
        bus.opb       = '0;
        bus.cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {bus.res, bus.cout, bus.oflow, bus.g, bus.l,
            bus.e, bus.err, bus.done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1, 2'b11, 1, 0, 'hFF, 'h01, 0);
        after_edge();
        chk("add_ff_01", {bus.res, bus.cout, bus.err}, {16'h0100, 2'b10});

        issue(1, 2'b11, 1, 8, 'h05, 'h09, 0);
        after_edge();
        chk("cmp_5_9", {bus.res, bus.g, bus.l, bus.e}, {16'h0, 3'b010});

        issue(1, 2'b11, 1, 9, 'h03, 'h04, 0);
        after_edge();
        chk("mul_inc_hold", bus.res, 32'h0);
        issue(1, 2'b11, 1, 0, 'h10, 'h20, 0);
        after_edge();
        chk("mul_inc_3_4", bus.res, 32'h0014);
        issue(0, 2'b11, 1, 0, 'h10, 'h20, 0);
        after_edge();
        chk("busy_add_dropped", bus.res, 32'h0014);

        issue(1, 2'b11, 0, 12, 'h81, 'h01, 0);
        after_edge();
        chk("rol_81_1", {bus.res, bus.err}, {16'h0003, 1'b0});
        issue(1, 2'b11, 0, 12, 'h81, 'h10, 0);
        after_edge();
        chk("rol_b_10_err", {bus.res, bus.err}, {16'h0081, 1'b1});

        issue(1, 2'b01, 1, 0, 'h12, 'h34, 0);
        after_edge();
        chk("add_missing_b", {bus.res, bus.err}, {16'h0, 1'b1});
        issue(1, 2'b01, 0, 6, 'h01, 'h77, 0);
        after_edge();
        chk("not_a", {bus.res, bus.err}, {16'h00FE, 1'b0});

        for (int i = 0; i < 3; i++) begin
            issue(0, 2'($urandom), 1'($urandom), $urandom % 16,
                  $urandom % 256, $urandom % 256, $urandom % 2);
            after_edge();
            chk("ce0_hold", {bus.res, bus.err}, {16'h00FE, 1'b0});
        end

        issue(1, 2'b11, 1, 10, 'h40, 'h33, 0);
        reset_pulse();
        after_edge();
        chk("no_stale_product", bus.res, 32'h0);

        issue(1, 2'b11, 1, 10, 'h03, 'h05, 0);
        issue(0, 2'b11, 1, 0, 'h01, 'h01, 0);
        after_edge();
        chk("stall_not_landed", bus.res, 32'h0);
        issue(1, 2'b11, 1, 0, 'h01, 'h01, 0);
        after_edge();
        chk("mul_shl_3_5", bus.res, 32'h001E);

        for (int n = 0; n < 3000; n++) begin
            a = ($urandom % 6 == 0) ? (($urandom % 2) ? 255 : 0)
                                    : int'($urandom % 256);
            b = ($urandom % 6 == 0) ? (($urandom % 2) ? 255 : 0)
                                    : int'($urandom % 256);
            if ($urandom % 4 == 0) b = b % 16;
            issue($urandom % 8 != 0,
                  ($urandom % 6 == 0) ? 2'($urandom) : 2'b11,
                  1'($urandom), $urandom % 16, a, b, $urandom % 2);
            if (n % 700 == 350) reset_pulse();
        end

        issue(1, 2'b00, 1, 0, 0, 0, 0);
        issue(1, 2'b00, 1, 0, 0, 0, 0);
        issue(0, 2'b00, 1, 0, 0, 0, 0);
        issue(0, 2'b00, 1, 0, 0, 0, 0);
        after_edge();
        chk("queue_drained", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
